// File: rtl/avm_ps2_fifo_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | avm_ps2_fifo_controller                                                  |
// | Avalon-MM PS/2 host: buffered RX FIFO, sticky errors, IRQ threshold,     |
// | optional host-to-device TX path enabled by defining PS2_TX_EN.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module avm_ps2_fifo_controller #(
  parameter int SYSCLK     = 50,
  parameter int DEPTH      = 16,
  parameter int TIMEOUT_US = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  avm_address,
  input  logic        avm_select,
  input  logic        avm_read,
  input  logic        avm_write,
  input  logic [31:0] avm_writedata,
  output logic [31:0] avm_readdata,
  input  logic        ps2_data_i,
  output logic        ps2_data_w,
  output logic        ps2_data_o,
  input  logic        ps2_clk_i,
  output logic        ps2_clk_w,
  output logic        ps2_clk_o,
  output logic        ps2_irq
);
  localparam int              c_AW     = $clog2(DEPTH);
  localparam logic [31:0]     c_TO_CYC = 32'(TIMEOUT_US * SYSCLK);
  localparam logic [c_AW:0]   c_FULL   = (c_AW + 1)'(DEPTH);

  logic [1:0] r_clk_sync, r_dat_sync;
  logic       r_clk_prev;
  logic       w_clk, w_dat, w_fall;
  logic       w_rd, w_wr, w_st_wr, w_pop;
  logic       w_tx_busy, w_tx_nack, w_rx_en;
  logic       w_unused;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2_clk_i};
      r_dat_sync <= {r_dat_sync[0], ps2_data_i};
      r_clk_prev <= r_clk_sync[1];
    end
  end

  assign w_clk    = r_clk_sync[1];
  assign w_dat    = r_dat_sync[1];
  assign w_fall   = r_clk_prev & ~w_clk;
  assign w_rd     = avm_select & avm_read;
  assign w_wr     = avm_select & avm_write;
  assign w_st_wr  = w_wr & (avm_address == 3'd1);
  assign w_unused = &{1'b0, avm_writedata[31:8]};

  // RX framing: cnt 0 = hunting for start, 1..9 = shifting D0..D7+parity, 10 = stop
  logic [3:0]  r_rx_cnt;
  logic [8:0]  r_rx_sh;
  logic [31:0] r_rx_tmr;
  logic        w_frame_end, w_good, w_push, w_perr_set;

  always_ff @(posedge clk) begin
    if (rst || !w_rx_en) begin
      r_rx_cnt <= 4'd0;
      r_rx_tmr <= 32'd0;
      r_rx_sh  <= 9'd0;
    end else if (w_fall) begin
      r_rx_tmr <= 32'd0;
      if (r_rx_cnt == 4'd0) begin
        if (!w_dat) r_rx_cnt <= 4'd1;
      end else if (r_rx_cnt == 4'd10) begin
        r_rx_cnt <= 4'd0;
      end else begin
        r_rx_sh  <= {w_dat, r_rx_sh[8:1]};
        r_rx_cnt <= r_rx_cnt + 4'd1;
      end
    end else if (r_rx_cnt != 4'd0) begin
      if (r_rx_tmr == c_TO_CYC - 32'd1) begin
        r_rx_cnt <= 4'd0;
        r_rx_tmr <= 32'd0;
      end else begin
        r_rx_tmr <= r_rx_tmr + 32'd1;
      end
    end
  end

  assign w_frame_end = w_rx_en & w_fall & (r_rx_cnt == 4'd10);
  assign w_good      = w_dat & (^r_rx_sh);
  assign w_push      = w_frame_end & w_good;
  assign w_perr_set  = w_frame_end & ~w_good;

  logic [7:0]      r_mem [DEPTH];
  logic [c_AW-1:0] r_wp, r_rp;
  logic [c_AW:0]   r_count;
  logic            w_full, w_ne, w_do_push, w_ovf_set;
  logic [7:0]      w_cnt8;

  assign w_full    = (r_count == c_FULL);
  assign w_ne      = (r_count != '0);
  assign w_pop     = w_rd & (avm_address == 3'd0) & w_ne;
  assign w_do_push = w_push & (~w_full | w_pop);
  assign w_ovf_set = w_push & w_full & ~w_pop;
  assign w_cnt8    = 8'(r_count);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wp] <= r_rx_sh[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + 1'b1;
      if (w_pop)     r_rp <= r_rp + 1'b1;
      if (w_do_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

  logic       r_rx_en, r_irq_en, r_perr, r_ovf;
  logic [7:0] r_thresh;
  logic [7:0] w_thr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_en  <= 1'b1;
      r_irq_en <= 1'b0;
      r_thresh <= 8'd1;
      r_perr   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr && avm_address == 3'd2) begin
        r_rx_en  <= avm_writedata[0];
        r_irq_en <= avm_writedata[1];
      end
      if (w_wr && avm_address == 3'd3) r_thresh <= avm_writedata[7:0];
      if (w_st_wr && avm_writedata[3]) r_perr <= 1'b0;
      if (w_st_wr && avm_writedata[4]) r_ovf  <= 1'b0;
      // A new error in the same cycle as a clear keeps the bit set
      if (w_perr_set) r_perr <= 1'b1;
      if (w_ovf_set)  r_ovf  <= 1'b1;
    end
  end

  assign w_rx_en = r_rx_en & ~w_tx_busy;
  assign w_thr   = (r_thresh == 8'd0) ? 8'd1 : r_thresh;
  assign ps2_irq = r_irq_en & ((w_cnt8 >= w_thr) | r_perr | r_ovf | w_tx_nack);

  logic [31:0] r_rdata;
  logic [31:0] w_status;
  assign w_status = {16'd0, w_cnt8, 2'b00, w_tx_nack, r_ovf, r_perr, w_tx_busy, w_full, w_ne};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= 32'd0;
    end else begin
      r_rdata <= 32'd0;
      if (w_rd) begin
        case (avm_address)
          3'd0:    r_rdata <= {23'd0, w_ne, (w_ne ? r_mem[r_rp] : 8'd0)};
          3'd1:    r_rdata <= w_status;
          3'd2:    r_rdata <= {30'd0, r_irq_en, r_rx_en};
          3'd3:    r_rdata <= {24'd0, r_thresh};
          default: r_rdata <= 32'd0;
        endcase
      end
    end
  end

  assign avm_readdata = r_rdata;
  assign ps2_data_o   = 1'b0;
  assign ps2_clk_o    = 1'b0;

`ifdef PS2_TX_EN
  localparam logic [2:0]  c_ST_IDLE    = 3'd0;
  localparam logic [2:0]  c_ST_INHIBIT = 3'd1;
  localparam logic [2:0]  c_ST_REQ     = 3'd2;
  localparam logic [2:0]  c_ST_SHIFT   = 3'd3;
  localparam logic [2:0]  c_ST_ACK     = 3'd4;
  localparam logic [2:0]  c_ST_WAIT_HI = 3'd5;
  localparam logic [31:0] c_INH_CYC    = 32'(100 * SYSCLK);

  logic [2:0]  r_st;
  logic [7:0]  r_tx_byte;
  logic        r_tx_par, r_tx_nack, r_data_w, r_clk_w;
  logic [3:0]  r_tx_bit;
  logic [31:0] r_tx_tmr;
  logic        w_tx_start, w_tx_wait;

  assign w_tx_start = w_wr & (avm_address == 3'd0) & (r_st == c_ST_IDLE);
  assign w_tx_wait  = (r_st == c_ST_REQ) | (r_st == c_ST_SHIFT) | (r_st == c_ST_ACK);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st      <= c_ST_IDLE;
      r_tx_byte <= 8'd0;
      r_tx_par  <= 1'b0;
      r_tx_nack <= 1'b0;
      r_data_w  <= 1'b0;
      r_clk_w   <= 1'b0;
      r_tx_bit  <= 4'd0;
      r_tx_tmr  <= 32'd0;
    end else begin
      if (w_st_wr && avm_writedata[5]) r_tx_nack <= 1'b0;
      case (r_st)
        c_ST_IDLE: if (w_tx_start) begin
          r_tx_byte <= avm_writedata[7:0];
          r_tx_par  <= ~^avm_writedata[7:0];
          r_tx_tmr  <= 32'd0;
          r_clk_w   <= 1'b1;
          r_st      <= c_ST_INHIBIT;
        end
        c_ST_INHIBIT: if (r_tx_tmr == c_INH_CYC - 32'd1) begin
          r_tx_tmr <= 32'd0;
          r_clk_w  <= 1'b0;
          r_data_w <= 1'b1;
          r_tx_bit <= 4'd0;
          r_st     <= c_ST_REQ;
        end else begin
          r_tx_tmr <= r_tx_tmr + 32'd1;
        end
        // Bit index 0..7 = data, 8 = parity, 9 = stop (line released)
        c_ST_REQ, c_ST_SHIFT: if (w_fall) begin
          r_tx_tmr <= 32'd0;
          if (r_tx_bit == 4'd9) begin
            r_data_w <= 1'b0;
            r_st     <= c_ST_ACK;
          end else begin
            r_data_w <= ~((r_tx_bit == 4'd8) ? r_tx_par : r_tx_byte[r_tx_bit[2:0]]);
            r_tx_bit <= r_tx_bit + 4'd1;
            r_st     <= c_ST_SHIFT;
          end
        end
        c_ST_ACK: if (w_fall) begin
          r_tx_tmr <= 32'd0;
          if (w_dat) r_tx_nack <= 1'b1;
          r_st <= c_ST_WAIT_HI;
        end
        c_ST_WAIT_HI: if (w_clk) r_st <= c_ST_IDLE;
        default: r_st <= c_ST_IDLE;
      endcase
      if (w_tx_wait && !w_fall) begin
        if (r_tx_tmr == c_TO_CYC - 32'd1) begin
          r_tx_nack <= 1'b1;
          r_data_w  <= 1'b0;
          r_clk_w   <= 1'b0;
          r_tx_tmr  <= 32'd0;
          r_st      <= c_ST_IDLE;
        end else begin
          r_tx_tmr <= r_tx_tmr + 32'd1;
        end
      end
    end
  end

  assign w_tx_busy  = (r_st != c_ST_IDLE);
  assign w_tx_nack  = r_tx_nack;
  assign ps2_data_w = r_data_w;
  assign ps2_clk_w  = r_clk_w;
`else
  assign w_tx_busy  = 1'b0;
  assign w_tx_nack  = 1'b0;
  assign ps2_data_w = 1'b0;
  assign ps2_clk_w  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_avm_ps2_fifo_controller.sv
`default_nettype none
// Testbench for avm_ps2_fifo_controller: directed steps plus randomized frames
// checked against a queue-based reference model.
module tb_avm_ps2_fifo_controller;
  localparam int SYSCLK     = 1;
  localparam int DEPTH      = 16;
  localparam int TIMEOUT_US = 200;
  localparam int HP         = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  avm_address = 3'd0;
  logic        avm_select = 1'b0, avm_read = 1'b0, avm_write = 1'b0;
  logic [31:0] avm_writedata = 32'd0;
  logic [31:0] avm_readdata;
  logic        ps2_data_i, ps2_data_w, ps2_data_o;
  logic        ps2_clk_i, ps2_clk_w, ps2_clk_o;
  logic        ps2_irq;
  logic        dev_clk = 1'b1, dev_dat = 1'b1;

  int total = 0;
  int bad   = 0;

  assign ps2_clk_i  = dev_clk & ~ps2_clk_w;
  assign ps2_data_i = dev_dat & ~ps2_data_w;

  always #5 clk = ~clk;

  avm_ps2_fifo_controller #(.SYSCLK(SYSCLK), .DEPTH(DEPTH), .TIMEOUT_US(TIMEOUT_US)) dut (
    .clk(clk), .rst(rst),
    .avm_address(avm_address), .avm_select(avm_select), .avm_read(avm_read),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .ps2_data_i(ps2_data_i), .ps2_data_w(ps2_data_w), .ps2_data_o(ps2_data_o),
    .ps2_clk_i(ps2_clk_i), .ps2_clk_w(ps2_clk_w), .ps2_clk_o(ps2_clk_o),
    .ps2_irq(ps2_irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    avm_address = a; avm_select = 1'b1; avm_read = 1'b1;
    @(negedge clk);
    avm_select = 1'b0; avm_read = 1'b0;
    d = avm_readdata;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] v);
    avm_address = a; avm_writedata = v; avm_select = 1'b1; avm_write = 1'b1;
    @(negedge clk);
    avm_select = 1'b0; avm_write = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    dev_dat = b;
    repeat (HP) @(negedge clk);
    dev_clk = 1'b0;
    repeat (HP) @(negedge clk);
    dev_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic badpar);
    logic p;
    p = (~^b) ^ badpar;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    send_bit(1'b1);
    repeat (HP) @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  q[$];
    logic        m_perr, m_ovf;
    logic [9:0]  rx;
    int          n;

    repeat (4) @(negedge clk);
    chk("rst_readdata", avm_readdata, 32'd0);
    chk("rst_pads", {28'd0, ps2_data_w, ps2_clk_w, ps2_data_o, ps2_clk_o}, 32'd0);
    chk("rst_irq", {31'd0, ps2_irq}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    bus_read(3'd1, d); chk("rst_status", d, 32'd0);
    bus_read(3'd2, d); chk("rst_ctrl", d, 32'd1);
    bus_read(3'd3, d); chk("rst_thresh", d, 32'd1);

    // good frame, then empty read
    send_frame(8'h1C, 1'b0);
    bus_read(3'd1, d); chk("one_status", d, 32'h0000_0101);
    bus_read(3'd0, d); chk("one_data", d, 32'h11C);
    bus_read(3'd0, d); chk("empty_data", d, 32'h000);
    bus_read(3'd1, d); chk("one_status_after", d, 32'd0);

    // parity error
    send_frame(8'h1C, 1'b1);
    bus_read(3'd1, d); chk("perr_status", d, 32'h08);
    bus_write(3'd1, 32'h08);
    bus_read(3'd1, d); chk("perr_clear", d, 32'd0);

    // overflow
    for (int i = 0; i <= DEPTH; i++) send_frame(8'(i), 1'b0);
    bus_read(3'd1, d); chk("ovf_status", d, 32'h0000_1013);
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(3'd0, d); chk("ovf_drain", d, 32'h100 | 32'(i));
    end
    bus_write(3'd1, 32'h10);
    bus_read(3'd1, d); chk("ovf_clear", d, 32'd0);

    // unused addresses
    bus_write(3'd6, 32'hFFFF_FFFF);
    bus_read(3'd5, d); chk("addr5_zero", d, 32'd0);
    bus_read(3'd2, d); chk("ctrl_unchanged", d, 32'd1);

    // interrupt threshold
    bus_write(3'd3, 32'd3);
    bus_write(3'd2, 32'd3);
    send_frame(8'h21, 1'b0);
    send_frame(8'h22, 1'b0);
    chk("irq_below", {31'd0, ps2_irq}, 32'd0);
    send_frame(8'h23, 1'b0);
    chk("irq_at", {31'd0, ps2_irq}, 32'd1);
    bus_read(3'd0, d); chk("irq_pop_data", d, 32'h121);
    chk("irq_after_pop", {31'd0, ps2_irq}, 32'd0);
    bus_write(3'd3, 32'd0);
    chk("irq_thresh0", {31'd0, ps2_irq}, 32'd1);
    bus_read(3'd0, d); chk("irq_d2", d, 32'h122);
    bus_read(3'd0, d); chk("irq_d3", d, 32'h123);
    chk("irq_empty", {31'd0, ps2_irq}, 32'd0);
    bus_write(3'd3, 32'd1);
    bus_write(3'd2, 32'd1);

    // partial frame abandoned by bit gap
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    repeat (TIMEOUT_US * SYSCLK + 100) @(negedge clk);
    send_frame(8'hAA, 1'b0);
    bus_read(3'd0, d); chk("gap_data", d, 32'h1AA);
    bus_read(3'd0, d); chk("gap_empty", d, 32'h000);

    // randomized frames vs queue model
    m_perr = 1'b0; m_ovf = 1'b0;
    for (int k = 0; k < 22; k++) begin
      logic [7:0] b;
      logic       bp;
      b  = 8'($urandom);
      bp = ($urandom_range(0, 3) == 0);
      send_frame(b, bp);
      if (bp) m_perr = 1'b1;
      else if (q.size() < DEPTH) q.push_back(b);
      else m_ovf = 1'b1;
    end
    bus_read(3'd1, d);
    chk("rand_status", d, {16'd0, 8'(q.size()), 3'b000, m_ovf, m_perr, 1'b0,
                           (q.size() == DEPTH), (q.size() != 0)});
    while (q.size() != 0) begin
      logic [7:0] e;
      e = q.pop_front();
      bus_read(3'd0, d); chk("rand_data", d, {23'd0, 1'b1, e});
    end
    bus_read(3'd0, d); chk("rand_empty", d, 32'd0);
    bus_write(3'd1, 32'h38);
    bus_read(3'd1, d); chk("rand_clear", d, 32'd0);

    // reset in the middle of a received frame
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    send_frame(8'h3C, 1'b0);
    bus_read(3'd0, d); chk("rst_rx_data", d, 32'h13C);

`ifdef PS2_TX_EN
    bus_write(3'd0, 32'hFF);
    n = 0;
    while (ps2_clk_w && n < 1000) begin n++; @(negedge clk); end
    chk("tx_inhibit_len", 32'(n), 32'(100 * SYSCLK));
    chk("tx_req_data_w", {31'd0, ps2_data_w}, 32'd1);
    rx = 10'd0;
    for (int k = 0; k < 10; k++) begin
      repeat (HP) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HP) @(negedge clk);
      rx[k] = ps2_data_i;
      dev_clk = 1'b1;
    end
    chk("tx_rx_byte", {22'd0, rx}, {22'd0, 1'b1, 1'b1, 8'hFF});
    repeat (HP / 2) @(negedge clk);
    dev_dat = 1'b0;
    repeat (HP - HP / 2) @(negedge clk);
    dev_clk = 1'b0;
    repeat (HP) @(negedge clk);
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    repeat (HP) @(negedge clk);
    bus_read(3'd1, d); chk("tx_done_status", d, 32'd0);

    // device never clocks
    bus_write(3'd0, 32'h12);
    repeat (100 * SYSCLK + TIMEOUT_US * SYSCLK + 20) @(negedge clk);
    chk("tx_to_lines", {30'd0, ps2_data_w, ps2_clk_w}, 32'd0);
    bus_read(3'd1, d); chk("tx_to_status", d, 32'h20);
    bus_write(3'd1, 32'h20);
    bus_read(3'd1, d); chk("tx_to_clear", d, 32'd0);

    // reset during TX
    bus_write(3'd0, 32'h55);
    repeat (20) @(negedge clk);
    chk("tx_mid_busy", {31'd0, ps2_clk_w}, 32'd1);
    rst = 1'b1; @(negedge clk);
    chk("tx_rst_lines", {30'd0, ps2_data_w, ps2_clk_w}, 32'd0);
    rst = 1'b0; @(negedge clk);
    bus_read(3'd1, d); chk("tx_rst_status", d, 32'd0);
`else
    bus_write(3'd0, 32'h55);
    chk("notx_lines", {30'd0, ps2_data_w, ps2_clk_w}, 32'd0);
    bus_read(3'd1, d); chk("notx_status", d, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
